// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage sitting directly in front of the IF/ID register.
// Owns the PC, drives the instruction-memory request/response handshake,
// holds a returned word while the pipeline is stalled and applies branch/jump
// redirects, including redirects that land while a request is still pending.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   cu_stall       downstream stall: keep presenting the current instruction
//   branch_taken   redirect from EX (wins over jump_taken)
//   branch_target  branch destination
//   jump_taken     redirect from ID
//   jump_target    jump destination
//   imem_req       memory request valid
//   imem_addr      memory request address
//   imem_rdata     returned word, valid while imem_ready=1
//   imem_ready     response valid (may coincide with imem_req)
//   pc             address of the presented instruction
//   pc_4           pc + 4
//   instr          presented instruction, 0 (NOP) when not valid
//   fetch_busy     no valid instruction this cycle
//   fetch_timeout  sticky memory-hang flag
//   fetch_misalign (only with IFETCH_ALIGN_CHK_EN) misaligned PC in FETCH
//
// Build option
//   IFETCH_ALIGN_CHK_EN : when defined, a misaligned PC in FETCH suppresses
//   the memory request, presents a NOP bubble (fetch_busy=0) and raises
//   fetch_misalign until a redirect arrives. When undefined, pc[1:0] is
//   passed to memory unchanged and no fetch_misalign port exists.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cu_stall,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  jump_taken,
    input  logic [PC_WIDTH-1:0]   jump_target,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_4,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  fetch_busy,
`ifdef IFETCH_ALIGN_CHK_EN
    output logic                  fetch_misalign,
`endif
    output logic                  fetch_timeout
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [PC_WIDTH-1:0]     pc_q,       pc_d;
    logic [DATA_WIDTH-1:0]   hold_q,     hold_d;
    logic [PC_WIDTH-1:0]     pend_q,     pend_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    timeout_q,  timeout_d;

    logic                    redir;
    logic [PC_WIDTH-1:0]     tgt;
    logic                    misalign;
    logic [PC_WIDTH-1:0]     pc_next_seq;

    // Redirect selection: the branch comes from the older instruction in EX,
    // so it overrides a jump decoded in ID during the same cycle.
    always_comb begin
        redir = branch_taken | jump_taken;
        tgt   = branch_taken ? branch_target : jump_target;
    end

    always_comb begin
        misalign = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
        misalign = (state_q == S_FETCH) && (pc_q[1:0] != 2'b00);
`endif
    end

    assign pc_next_seq = pc_q + PC_WIDTH'(4);

    // Output decode
    always_comb begin
        imem_req  = !reset && (state_q != S_HOLD) && !misalign;
        imem_addr = pc_q;
        pc        = pc_q;
        pc_4      = pc_next_seq;

        instr      = '0;
        fetch_busy = 1'b1;
        if (misalign) begin
            // NOP bubble so the downstream exception logic sees a slot
            instr      = '0;
            fetch_busy = 1'b0;
        end else if (state_q == S_FETCH && imem_ready) begin
            instr      = imem_rdata;
            fetch_busy = 1'b0;
        end else if (state_q == S_HOLD) begin
            instr      = hold_q;
            fetch_busy = 1'b0;
        end
    end

`ifdef IFETCH_ALIGN_CHK_EN
    assign fetch_misalign = !reset && misalign;
`endif

    assign fetch_timeout = timeout_q;

    // Next-state logic; priority is redirect > stall > sequential advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        pend_d  = pend_q;

        case (state_q)
            S_FETCH: begin
                if (misalign) begin
                    // Parked on the bad PC until control flow is redirected
                    if (redir) begin
                        pc_d = tgt;
                    end
                end else if (!imem_ready) begin
                    if (redir) begin
                        // Request already issued cannot be cancelled: let it
                        // complete and remember where to go afterwards.
                        pend_d  = tgt;
                        state_d = S_DRAIN;
                    end
                end else begin
                    if (redir) begin
                        pc_d = tgt;
                    end else if (cu_stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_next_seq;
                    end
                end
            end

            S_HOLD: begin
                if (redir) begin
                    pc_d    = tgt;
                    state_d = S_FETCH;
                end else if (!cu_stall) begin
                    pc_d    = pc_next_seq;
                    state_d = S_FETCH;
                end
            end

            S_DRAIN: begin
                if (redir) begin
                    pend_d = tgt;
                end
                if (imem_ready) begin
                    // Stale word is dropped; the newest redirect wins
                    pc_d    = redir ? tgt : pend_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Memory-hang detection: count consecutive unanswered request cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (imem_ready) begin
            wait_cnt_d = '0;
        end else if (imem_req && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q | (wait_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            hold_q     <= '0;
            pend_q     <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int MAXW = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cu_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump_taken = 1'b0;
    logic [31:0] jump_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instr;
    logic        fetch_busy;
    logic        fetch_timeout;
`ifdef IFETCH_ALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    int checks = 0;
    int failures = 0;

    if_fetch_unit #(
        .PC_WIDTH  (32),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cu_stall      (cu_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .pc_4          (pc_4),
        .instr         (instr),
        .fetch_busy    (fetch_busy),
`ifdef IFETCH_ALIGN_CHK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // Drive one cycle's inputs (called just after a falling edge), then let
    // combinational outputs settle before the caller samples them.
    task automatic apply(input logic rdy, input logic [31:0] rd, input logic st,
                         input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        imem_ready    = rdy;
        imem_rdata    = rd;
        cu_stall      = st;
        branch_taken  = br;
        branch_target = bt;
        jump_taken    = jp;
        jump_target   = jt;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sequential fetch with a zero-wait memory for n cycles
    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, pc, fetch_timeout} !== {1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got req=%b pc=%h to=%b exp req=0 pc=0 to=0",
                     imem_req, pc, fetch_timeout);
        end
        reset = 1'b0;
        stream(3);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'hC) begin
            failures++;
            $display("FAIL reset_prestream got pc=%h exp=0000000c", pc);
        end
        // Asynchronous: reset takes effect without waiting for a clock edge
        reset = 1'b1;
        #1;
        checks++;
        if ({pc, imem_req, fetch_busy, instr} !== {32'h0, 1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_async got pc=%h req=%b busy=%b instr=%h exp pc=0 req=0 busy=1 instr=0",
                     pc, imem_req, fetch_busy, instr);
        end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if ({pc, pc_4, instr, fetch_busy, imem_req} !==
                {32'(i * 4), 32'(i * 4 + 4), 32'(i * 4), 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL zero_wait[%0d] got pc=%h pc4=%h instr=%h busy=%b req=%b exp pc=%h pc4=%h instr=%h busy=0 req=1",
                         i, pc, pc_4, instr, fetch_busy, imem_req, i * 4, i * 4 + 4, i * 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        stream(2);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if ({pc, imem_addr, instr, fetch_busy} !== {32'h8, 32'h8, 32'h0, 1'b1}) begin
                failures++;
                $display("FAIL wait_state[%0d] got pc=%h addr=%h instr=%h busy=%b exp pc=8 addr=8 instr=0 busy=1",
                         i, pc, imem_addr, instr, fetch_busy);
            end
            @(negedge clk);
        end
        apply(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({pc, instr, fetch_busy} !== {32'h8, 32'h8, 1'b0}) begin
            failures++;
            $display("FAIL wait_deliver got pc=%h instr=%h busy=%b exp pc=8 instr=8 busy=0",
                     pc, instr, fetch_busy);
        end
        @(negedge clk);
        apply(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'hC) begin
            failures++;
            $display("FAIL wait_advance got pc=%h exp=0000000c", pc);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_hold();
        do_reset();
        stream(4);
        apply(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({pc, instr, fetch_busy} !== {32'h10, 32'hDEAD_BEEF, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got pc=%h instr=%h busy=%b exp pc=10 instr=deadbeef busy=0",
                         i, pc, instr, fetch_busy);
            end
            @(negedge clk);
            // memory bus carries garbage while holding; held word must persist
            apply(1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        checks++;
        if ({pc, instr, imem_req} !== {32'h10, 32'hDEAD_BEEF, 1'b0}) begin
            failures++;
            $display("FAIL stall_hold_late got pc=%h instr=%h req=%b exp pc=10 instr=deadbeef req=0",
                     pc, instr, imem_req);
        end
        @(negedge clk);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({pc, instr, fetch_busy} !== {32'h10, 32'hDEAD_BEEF, 1'b0}) begin
            failures++;
            $display("FAIL stall_release got pc=%h instr=%h busy=%b exp pc=10 instr=deadbeef busy=0",
                     pc, instr, fetch_busy);
        end
        @(negedge clk);
        apply(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({pc, instr} !== {32'h14, 32'h14}) begin
            failures++;
            $display("FAIL stall_after got pc=%h instr=%h exp pc=14 instr=14", pc, instr);
        end
        @(negedge clk);
    endtask

    task automatic test_simul_redirect();
        do_reset();
        apply(1'b1, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        @(negedge clk);
        apply(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h40) begin
            failures++;
            $display("FAIL simul_redirect got pc=%h exp=00000040", pc);
        end
        @(negedge clk);
        apply(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        @(negedge clk);
        apply(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h80) begin
            failures++;
            $display("FAIL jump_only got pc=%h exp=00000080", pc);
        end
        @(negedge clk);
    endtask

    task automatic test_drain();
        do_reset();
        stream(8);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        checks++;
        if ({imem_addr, fetch_busy} !== {32'h20, 1'b1}) begin
            failures++;
            $display("FAIL drain_start got addr=%h busy=%b exp addr=20 busy=1", imem_addr, fetch_busy);
        end
        @(negedge clk);
        apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_req, imem_addr, instr, fetch_busy} !== {1'b1, 32'h20, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL drain_wait got req=%b addr=%h instr=%h busy=%b exp req=1 addr=20 instr=0 busy=1",
                     imem_req, imem_addr, instr, fetch_busy);
        end
        @(negedge clk);
        apply(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_addr, instr, fetch_busy} !== {32'h20, 32'h0, 1'b1}) begin
            failures++;
            $display("FAIL drain_discard got addr=%h instr=%h busy=%b exp addr=20 instr=0 busy=1",
                     imem_addr, instr, fetch_busy);
        end
        @(negedge clk);
        apply(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if ({imem_req, imem_addr, pc, instr} !== {1'b1, 32'h100, 32'h100, 32'h100}) begin
            failures++;
            $display("FAIL drain_target got req=%b addr=%h pc=%h instr=%h exp req=1 addr=100 pc=100 instr=100",
                     imem_req, imem_addr, pc, instr);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k <= MAXW + 3; k++) begin
            apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checks++;
            if (fetch_timeout !== (k >= MAXW)) begin
                failures++;
                $display("FAIL timeout_count[%0d] got=%b exp=%b", k, fetch_timeout, k >= MAXW);
            end
            @(negedge clk);
        end
        stream(2);
        checks++;
        if (fetch_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", fetch_timeout);
        end
        do_reset();
        checks++;
        if (fetch_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", fetch_timeout);
        end
    endtask

    // Randomised traffic against a transaction-level reference: the model
    // tracks "what is presented" (a held word, a discarded in-flight request,
    // or a live request) and where control flow goes next.
    task automatic test_random();
        logic [31:0] m_pc;
        logic        m_holding;
        logic [31:0] m_word;
        logic        m_discard;
        logic [31:0] m_after;
        int          m_waits;
        logic        m_to;
        logic        rdy, st, br, jp, e_req, e_busy, redir;
        logic [31:0] rd, bt, jt, e_instr, t, dest;

        do_reset();
        m_pc = 32'h0; m_holding = 0; m_word = 0; m_discard = 0; m_after = 0;
        m_waits = 0; m_to = 0;

        for (int i = 0; i < 600; i++) begin
            if (i >= 300 && i < 320) rdy = 1'b0;
            else rdy = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 11) == 0);
            jp = ($urandom_range(0, 11) == 0);
            t  = $urandom; bt = {16'h0, t[15:2], 2'b00};
            t  = $urandom; jt = {16'h0, t[15:2], 2'b00};
            apply(rdy, rd, st, br, bt, jp, jt);

            e_req = !m_holding;
            if (m_holding) begin
                e_instr = m_word; e_busy = 1'b0;
            end else if (!m_discard && rdy) begin
                e_instr = rd; e_busy = 1'b0;
            end else begin
                e_instr = 32'h0; e_busy = 1'b1;
            end

            checks++;
            if ({pc, pc_4, imem_addr, imem_req, instr, fetch_busy, fetch_timeout} !==
                {m_pc, m_pc + 32'd4, m_pc, e_req, e_instr, e_busy, m_to}) begin
                failures++;
                $display("FAIL random[%0d] got pc=%h pc4=%h addr=%h req=%b instr=%h busy=%b to=%b exp pc=%h pc4=%h addr=%h req=%b instr=%h busy=%b to=%b",
                         i, pc, pc_4, imem_addr, imem_req, instr, fetch_busy, fetch_timeout,
                         m_pc, m_pc + 32'd4, m_pc, e_req, e_instr, e_busy, m_to);
            end

            redir = br | jp;
            dest  = br ? bt : jt;
            if (rdy) m_waits = 0;
            else if (e_req && m_waits < MAXW) m_waits++;
            if (m_waits >= MAXW) m_to = 1'b1;

            if (m_holding) begin
                if (redir) begin m_pc = dest; m_holding = 0; end
                else if (!st) begin m_pc = m_pc + 4; m_holding = 0; end
            end else if (m_discard) begin
                if (redir) m_after = dest;
                if (rdy) begin m_pc = m_after; m_discard = 0; end
            end else if (rdy) begin
                if (redir) m_pc = dest;
                else if (st) begin m_holding = 1; m_word = rd; end
                else m_pc = m_pc + 4;
            end else if (redir) begin
                m_discard = 1; m_after = dest;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_simul_redirect();
        test_drain();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
